// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcodes and default widths shared by the logic unit, its driver and the bench.
package logic_unit_pkg;
  localparam int DATA_SIZE    = 8;
  localparam int OP_CODE_SIZE = 2;
  localparam int ALU_LATENCY  = 2;
  localparam int FIFO_DEPTH   = 4;
  typedef enum logic [OP_CODE_SIZE-1:0] {
    OP_OR  = 2'b00,
    OP_XOR = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } op_e;
endpackage

// File: rtl/logic_unit_rsp_fifo.sv
// logic_unit_rsp_fifo: synchronous FIFO with occupancy count; reads as zero when empty.
module logic_unit_rsp_fifo #(
  parameter int width = 8,
  parameter int depth = 4,
  localparam int aw = depth > 1 ? $clog2(depth) : 1,
  localparam int cw = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic [cw-1:0]    count
);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic pop_ok;
  function automatic logic [aw-1:0] nxt(input logic [aw-1:0] p);
    return p == aw'(depth - 1) ? '0 : p + aw'(1);
  endfunction
  assign pop_ok = pop & (count != '0);
  assign dout = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop_ok) rd_ptr <= nxt(rd_ptr);
      count <= count + cw'(push) - cw'(pop_ok);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/logic_unit_driver.sv
// logic_unit_driver: credit-controlled issue into the logic unit with in-order response FIFO.
// Optional LOGIC_UNIT_DRIVER_STATS_EN adds issued/completed counters.
module logic_unit_driver
  import logic_unit_pkg::*;
#(
  parameter int data_size    = DATA_SIZE,
  parameter int op_code_size = OP_CODE_SIZE,
  parameter int alu_latency  = ALU_LATENCY,
  parameter int fifo_depth   = FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    cmd_valid_in,
  output logic                    cmd_ready_out,
  input  logic [data_size-1:0]    cmd_a_in,
  input  logic [data_size-1:0]    cmd_b_in,
  input  logic [op_code_size-1:0] cmd_op_in,
  output logic [data_size-1:0]    alu_a_out,
  output logic [data_size-1:0]    alu_b_out,
  output logic [op_code_size-1:0] alu_op_out,
  input  logic [data_size-1:0]    alu_result_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [data_size-1:0]    rsp_data_out,
  output logic                    busy_out
`ifdef LOGIC_UNIT_DRIVER_STATS_EN
  ,
  output logic [15:0]             issued_count_out,
  output logic [15:0]             completed_count_out
`endif
);
  localparam int iw = $clog2(alu_latency + 1);
  localparam int cw = $clog2(fifo_depth + 1);
  localparam int sw = $clog2(alu_latency + fifo_depth + 1);
  logic [alu_latency-1:0] tags;
  logic [iw-1:0] inflight;
  logic [cw-1:0] fifo_count;
  logic fire, push, pop;
  assign alu_a_out  = cmd_a_in;
  assign alu_b_out  = cmd_b_in;
  assign alu_op_out = cmd_op_in;
  assign fire = cmd_valid_in & cmd_ready_out;
  assign push = tags[alu_latency-1];
  assign pop  = rsp_valid_out & rsp_ready_in;
  // Credit counts every command not yet popped, so a result always has a slot waiting.
  assign cmd_ready_out = sw'(inflight) + sw'(fifo_count) < sw'(fifo_depth);
  assign rsp_valid_out = fifo_count != '0;
  assign busy_out = (inflight != '0) | rsp_valid_out;
  always_ff @(posedge clk) begin
    if (reset_in) begin
      tags     <= '0;
      inflight <= '0;
    end else begin
      tags     <= alu_latency'({tags, fire});
      inflight <= inflight + iw'(fire) - iw'(push);
    end
  end
  logic_unit_rsp_fifo #(.width(data_size), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (reset_in),
    .push  (push),
    .pop   (pop),
    .din   (alu_result_in),
    .dout  (rsp_data_out),
    .count (fifo_count)
  );
`ifdef LOGIC_UNIT_DRIVER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset_in) begin
      issued_count_out    <= '0;
      completed_count_out <= '0;
    end else begin
      issued_count_out    <= issued_count_out + 16'(fire);
      completed_count_out <= completed_count_out + 16'(pop);
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_driver.sv
// tb_logic_unit_driver: table vectors, corner sequences and random traffic against an outstanding-command queue model.
module tb_logic_unit_driver;
  import logic_unit_pkg::*;
  logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_data;
  logic [1:0] cmd_op = 0, alu_op;
  logic cmd_ready, rsp_valid, busy;
`ifdef LOGIC_UNIT_DRIVER_STATS_EN
  logic [15:0] issued, completed;
`endif
  always #5 clk = ~clk;

  logic_unit_driver dut (
    .clk(clk), .reset_in(reset), .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_a_in(cmd_a), .cmd_b_in(cmd_b), .cmd_op_in(cmd_op),
    .alu_a_out(alu_a), .alu_b_out(alu_b), .alu_op_out(alu_op), .alu_result_in(alu_result),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_data_out(rsp_data), .busy_out(busy)
`ifdef LOGIC_UNIT_DRIVER_STATS_EN
    , .issued_count_out(issued), .completed_count_out(completed)
`endif
  );

  function automatic logic [7:0] lu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      default: return ~a;
    endcase
  endfunction

  // Registered logic unit: inputs captured on one edge, result registered on the next.
  logic [7:0] lu_a, lu_b;
  logic [1:0] lu_op;
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_a <= 0; lu_b <= 0; lu_op <= 0; alu_result <= 0;
    end else begin
      lu_a <= alu_a; lu_b <= alu_b; lu_op <= alu_op;
      alu_result <= lu(lu_a, lu_b, lu_op);
    end
  end

  typedef struct { logic [7:0] exp; int e; } ent_t;
  ent_t q[$];
  logic [7:0] got[$];
  int pop_edges[$];
  int edge_n = 0, n_tests = 0, n_fail = 0, m_iss = 0, m_cmp = 0;
  bit fired, popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic bit m_ready();
    return q.size() < 4;
  endfunction
  function automatic bit m_valid();
    return q.size() != 0 && edge_n - q[0].e >= 2;
  endfunction

  task automatic step();
    bit f, p;
    logic [7:0] d, x;
    f = !reset && cmd_valid && m_ready();
    p = !reset && rsp_ready && m_valid();
    d = rsp_data;
    x = lu(cmd_a, cmd_b, cmd_op);
    @(posedge clk); #1;
    edge_n++;
    fired = f;
    popped = p;
    if (reset) begin
      q.delete(); m_iss = 0; m_cmp = 0;
    end else begin
      if (p) begin void'(q.pop_front()); got.push_back(d); pop_edges.push_back(edge_n); m_cmp++; end
      if (f) begin q.push_back('{exp: x, e: edge_n}); m_iss++; end
    end
    chk("cmd_ready", cmd_ready, m_ready());
    chk("rsp_valid", rsp_valid, m_valid());
    chk("busy", busy, q.size() != 0);
    if (m_valid()) chk("rsp_data", rsp_data, q[0].exp);
`ifdef LOGIC_UNIT_DRIVER_STATS_EN
    chk("issued", issued, m_iss[15:0]);
    chk("completed", completed, m_cmp[15:0]);
`endif
  endtask

  typedef struct { logic [7:0] a, b; logic [1:0] op; logic [7:0] exp; } vec_t;
  vec_t tbl[4];

  initial begin
    int lat, low, acc, stale;
    tbl[0] = '{8'hF0, 8'h0F, OP_OR,  8'hFF};
    tbl[1] = '{8'hF0, 8'h0F, OP_XOR, 8'hFF};
    tbl[2] = '{8'hF0, 8'h0F, OP_AND, 8'h00};
    tbl[3] = '{8'hA5, 8'h0F, OP_NOT, 8'h5A};
    reset = 1;
    repeat (2) step();
    reset = 0;
    chk("reset_data", rsp_data, 0);
    chk("reset_ready", cmd_ready, 1);

    foreach (tbl[i]) begin
      cmd_a = tbl[i].a; cmd_b = tbl[i].b; cmd_op = tbl[i].op; cmd_valid = 1;
      step();
      chk("op_fire", fired, 1);
      cmd_valid = 0;
      lat = 0;
      while (!rsp_valid && lat < 10) begin step(); lat++; end
      chk("op_latency", lat, 2);
      chk("op_result", rsp_data, tbl[i].exp);
      rsp_ready = 1; step(); rsp_ready = 0;
    end

    got.delete(); pop_edges.delete();
    rsp_ready = 1; low = 0;
    for (int i = 1; i <= 8; i++) begin
      cmd_a = 8'(i); cmd_b = 0; cmd_op = OP_OR; cmd_valid = 1;
      step();
      if (!fired || !cmd_ready) low++;
    end
    cmd_valid = 0;
    repeat (6) step();
    chk("stream_ready_low", low, 0);
    chk("stream_count", got.size(), 8);
    for (int j = 0; j < got.size(); j++) chk("stream_value", got[j], j + 1);
    for (int j = 1; j < pop_edges.size(); j++) chk("stream_gap", pop_edges[j] - pop_edges[j-1], 1);

    got.delete(); rsp_ready = 0; acc = 0; cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cmd_a = 8'h10 + 8'(acc); cmd_b = 0; cmd_op = OP_OR;
      step();
      if (fired) acc++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", cmd_ready, 0);
    cmd_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 20 && got.size() < 4; i++) begin
      step();
      if (popped && got.size() == 1) chk("bp_ready_after_pop", cmd_ready, 1);
    end
    chk("bp_count", got.size(), 4);
    for (int j = 0; j < got.size(); j++) chk("bp_order", got[j], 8'h10 + j);

    rsp_ready = 0; cmd_a = 8'h33; cmd_b = 8'h44; cmd_op = OP_XOR; cmd_valid = 1;
    repeat (2) step();
    cmd_valid = 0;
    step();
    reset = 1; step(); reset = 0;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_valid", rsp_valid, 0);
    rsp_ready = 1; stale = 0;
    repeat (6) begin step(); if (rsp_valid) stale++; end
    chk("mid_reset_stale", stale, 0);

    for (int i = 0; i < 3000; i++) begin
      cmd_valid = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 2) != 0;
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 2'($urandom);
      step();
    end
    cmd_valid = 0; rsp_ready = 1;
    repeat (8) step();
    chk("drain_busy", busy, 0);

`ifdef LOGIC_UNIT_DRIVER_STATS_EN
    reset = 1; step(); reset = 0;
    rsp_ready = 0; cmd_valid = 1;
    for (int i = 0; i < 10 && m_iss < 3; i++) step();
    cmd_valid = 0;
    repeat (3) step();
    rsp_ready = 1;
    for (int i = 0; i < 10 && m_cmp < 3; i++) step();
    rsp_ready = 0; cmd_valid = 1;
    for (int i = 0; i < 10 && m_iss < 5; i++) step();
    cmd_valid = 0;
    chk("stats_issued", issued, 5);
    chk("stats_completed", completed, 3);
    reset = 1; step(); reset = 0;
    rsp_ready = 1; cmd_valid = 1;
    for (int i = 0; i < 66000 && m_iss < 65536; i++) step();
    cmd_valid = 0;
    chk("stats_wrap_fires", m_iss, 65536);
    chk("stats_wrap", issued, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
